// File: rtl/uf_union_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uf_pkg
//  Description : Shared types and helpers for the union-find engine: FSM
//                state encoding, default sizing constants and root min/max
//                helpers used when linking two trees.
//  Revision    : 1.0 - initial release
// ============================================================================
package uf_pkg;

    // Default sizing; the engine derives its real widths from its own DEPTH.
    localparam int UF_DEPTH_DEFAULT = 1000;
    localparam int AW               = $clog2(UF_DEPTH_DEFAULT);
    localparam int CW               = $clog2(UF_DEPTH_DEFAULT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_LINK  = 3'd5
    } uf_state_t;

    function automatic int unsigned root_min(input int unsigned x, input int unsigned y);
        return (x < y) ? x : y;
    endfunction

    function automatic int unsigned root_max(input int unsigned x, input int unsigned y);
        return (x < y) ? y : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uf_union_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : uf_union_engine_if
//  Description : Edge request / merge result handshake of the union-find
//                engine.
//                master : upstream edge source, result consumer
//                slave  : the engine
//                edge_valid/edge_ready/edge_a/edge_b : edge request
//                res_valid/res_merged/res_root        : one-cycle result
//  Revision    : 1.0 - initial release
// ============================================================================
interface uf_union_engine_if
    import uf_pkg::*;
#(
    parameter int AW = 10
) ();
    logic          edge_valid;
    logic          edge_ready;
    logic [AW-1:0] edge_a;
    logic [AW-1:0] edge_b;
    logic          res_valid;
    logic          res_merged;
    logic [AW-1:0] res_root;

    modport master (
        output edge_valid, edge_a, edge_b,
        input  edge_ready, res_valid, res_merged, res_root
    );

    modport slave (
        input  edge_valid, edge_a, edge_b,
        output edge_ready, res_valid, res_merged, res_root
    );
endinterface
`default_nettype wire

// File: rtl/uf_union_engine_chase_port.sv
`default_nettype none
// ============================================================================
//  Module      : uf_chase_port
//  Description : One root-chasing lane. Holds the current node, hop count and
//                done flag for one RAM read port, keeps ren/raddr stable for
//                RD_LAT cycles per hop and evaluates the returned parent.
//  Ports       : clk, rst_n        clock, async active-low reset
//                i_load/i_node     start a new chase at i_node
//                i_issue           engine is in ISSUE/WAIT
//                i_check           engine is in CHECK (rdata valid)
//                i_rdata           RAM read data
//                o_ren/o_raddr     RAM read port
//                o_hold_last       last cycle of the ren hold window
//                o_cur             current node (the root once done)
//                o_fin             lane is done after this CHECK
//                o_hop_lim         this CHECK would take hop count to DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module uf_chase_port
    import uf_pkg::*;
#(
    parameter int DEPTH  = 1000,
    parameter int RD_LAT = 1,
    parameter int AW     = $clog2(DEPTH),
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_load,
    input  wire logic [AW-1:0] i_node,
    input  wire logic          i_issue,
    input  wire logic          i_check,
    input  wire logic [AW-1:0] i_rdata,
    output logic               o_ren,
    output logic [AW-1:0]      o_raddr,
    output logic               o_hold_last,
    output logic [AW-1:0]      o_cur,
    output logic               o_fin,
    output logic               o_hop_lim
);
    localparam int HW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic [AW-1:0] r_cur;
    logic [CW-1:0] r_hop;
    logic          r_done;
    logic [HW-1:0] r_cnt;
    logic          w_self;

    assign w_self = (i_rdata == r_cur);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur  <= '0;
            r_hop  <= '0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_cur  <= i_node;
            r_hop  <= '0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            // The hold counter runs even for a finished lane so both lanes
            // agree on when the read window closes.
            if (i_issue) begin
                r_cnt <= r_cnt + HW'(1);
            end else begin
                r_cnt <= '0;
            end
            if (i_check && !r_done) begin
                if (w_self) begin
                    r_done <= 1'b1;
                end else begin
                    r_cur <= i_rdata;
                    r_hop <= r_hop + CW'(1);
                end
            end
        end
    end

    // A finished lane stops shifting the RAM read pipeline.
    assign o_ren       = i_issue && !r_done;
    assign o_raddr     = r_cur;
    assign o_hold_last = (r_cnt == HW'(RD_LAT - 1));
    assign o_cur       = r_cur;
    assign o_fin       = r_done || w_self;
    assign o_hop_lim   = i_check && !r_done && !w_self && (r_hop == CW'(DEPTH - 1));

endmodule
`default_nettype wire

// File: rtl/uf_union_engine.sv
`default_nettype none
// ============================================================================
//  Module      : uf_union_engine
//  Description : Union-find engine driving a 2R+2W parent-pointer RAM.
//                Initialises parent[k]=k, then for each edge (a,b) chases both
//                roots in parallel and links the larger root under the
//                smaller one. Reports a per-edge result and component count.
//  Ports       : clk, rst_n            clock, async active-low reset
//                i_init_start          (re)initialise the parent table
//                o_init_done           table is identity / engine usable
//                bus (slave)           edge request / result handshake
//                o_comp_count          current number of components
//                o_err                 sticky: a chase exceeded DEPTH hops
//                o_ram_*               two read and two write RAM ports
//  Revision    : 1.0 - initial release
// ============================================================================
module uf_union_engine
    import uf_pkg::*;
#(
    parameter int DEPTH  = 1000,
    parameter int RD_LAT = 1,
    parameter int AW     = $clog2(DEPTH)
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       i_init_start,
    output logic                            o_init_done,
    uf_union_engine_if.slave                bus,
    output logic [$clog2(DEPTH+1)-1:0]      o_comp_count,
    output logic                            o_err,
    output logic [AW-1:0]                   o_ram_raddr [2],
    output logic                            o_ram_ren   [2],
    input  wire logic [AW-1:0]              i_ram_rdata [2],
    output logic [AW-1:0]                   o_ram_waddr [2],
    output logic                            o_ram_wen   [2],
    output logic [AW-1:0]                   o_ram_wdata [2]
);
    localparam int CW = $clog2(DEPTH + 1);

    if (RD_LAT < 1) begin : g_bad_rd_lat
        $fatal(1, "uf_union_engine: RD_LAT must be >= 1");
    end

    uf_state_t     r_state;
    uf_state_t     w_state_nx;
    logic [CW-1:0] r_k;
    logic          r_init_done;
    logic [CW-1:0] r_comp_count;
    logic          r_err;

    logic          w_ready;
    logic          w_accept;
    logic          w_issue;
    logic          w_check;
    logic          w_init_last;
    logic          w_port1_on;
    logic          w_merge;
    logic [AW-1:0] w_rmin;
    logic [AW-1:0] w_rmax;

    logic [AW-1:0] w_cur       [2];
    logic          w_fin       [2];
    logic          w_hop_lim   [2];
    logic          w_hold_last [2];

    logic          w_res_valid;
    logic          w_res_merged;
    logic [AW-1:0] w_res_root;
    logic          w_wen0;
    logic [AW-1:0] w_waddr0;
    logic [AW-1:0] w_wdata0;
    logic          w_wen1;
    logic [AW-1:0] w_waddr1;
    logic [AW-1:0] w_wdata1;
    logic          w_link_dec;
    logic          w_err_set;

    assign w_ready     = (r_state == S_IDLE) && r_init_done;
    assign w_accept    = bus.edge_valid && w_ready && !i_init_start;
    assign w_issue     = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_check     = (r_state == S_CHECK);
    assign w_init_last = (int'(r_k) + 2 >= DEPTH);
    assign w_port1_on  = (int'(r_k) + 1 < DEPTH);
    assign w_merge     = (w_cur[0] != w_cur[1]);
    assign w_rmin      = AW'(root_min(32'(w_cur[0]), 32'(w_cur[1])));
    assign w_rmax      = AW'(root_max(32'(w_cur[0]), 32'(w_cur[1])));

    for (genvar g = 0; g < 2; g++) begin : g_port
        uf_chase_port #(
            .DEPTH  (DEPTH),
            .RD_LAT (RD_LAT),
            .AW     (AW),
            .CW     (CW)
        ) u_chase (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_load      (w_accept),
            .i_node      ((g == 0) ? bus.edge_a : bus.edge_b),
            .i_issue     (w_issue),
            .i_check     (w_check),
            .i_rdata     (i_ram_rdata[g]),
            .o_ren       (o_ram_ren[g]),
            .o_raddr     (o_ram_raddr[g]),
            .o_hold_last (w_hold_last[g]),
            .o_cur       (w_cur[g]),
            .o_fin       (w_fin[g]),
            .o_hop_lim   (w_hop_lim[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_res_valid  = 1'b0;
        w_res_merged = 1'b0;
        w_res_root   = '0;
        w_wen0       = 1'b0;
        w_waddr0     = '0;
        w_wdata0     = '0;
        w_wen1       = 1'b0;
        w_waddr1     = '0;
        w_wdata1     = '0;
        w_link_dec   = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = S_ISSUE;
                end
            end
            S_INIT: begin
                w_wen0   = 1'b1;
                w_waddr0 = AW'(r_k);
                w_wdata0 = AW'(r_k);
                w_wen1   = w_port1_on;
                w_waddr1 = w_port1_on ? AW'(r_k + CW'(1)) : '0;
                w_wdata1 = w_port1_on ? AW'(r_k + CW'(1)) : '0;
                if (w_init_last) begin
                    w_state_nx = S_IDLE;
                end
            end
            S_ISSUE, S_WAIT: begin
                w_state_nx = (w_hold_last[0] && w_hold_last[1]) ? S_CHECK : S_WAIT;
            end
            S_CHECK: begin
                if (w_hop_lim[0] || w_hop_lim[1]) begin
                    // Runaway chase (corrupt table): give up on this edge.
                    w_state_nx  = S_IDLE;
                    w_res_valid = 1'b1;
                    w_res_root  = w_cur[0];
                    w_err_set   = 1'b1;
                end else if (w_fin[0] && w_fin[1]) begin
                    w_state_nx = S_LINK;
                end else begin
                    w_state_nx = S_ISSUE;
                end
            end
            S_LINK: begin
                w_state_nx   = S_IDLE;
                w_res_valid  = 1'b1;
                w_res_merged = w_merge;
                w_res_root   = w_rmin;
                w_wen0       = w_merge;
                w_waddr0     = w_merge ? w_rmax : '0;
                w_wdata0     = w_merge ? w_rmin : '0;
                w_link_dec   = w_merge;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        // Re-initialisation wins over everything; an in-flight edge is
        // discarded without a result or a link write.
        if (i_init_start) begin
            w_state_nx   = S_INIT;
            w_res_valid  = 1'b0;
            w_res_merged = 1'b0;
            w_res_root   = '0;
            w_link_dec   = 1'b0;
            w_err_set    = 1'b0;
            if (r_state != S_INIT) begin
                w_wen0   = 1'b0;
                w_waddr0 = '0;
                w_wdata0 = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k          <= '0;
            r_init_done  <= 1'b0;
            r_comp_count <= '0;
            r_err        <= 1'b0;
        end else if (i_init_start) begin
            r_k         <= '0;
            r_init_done <= 1'b0;
        end else begin
            if (r_state == S_INIT) begin
                r_k <= r_k + CW'(2);
                if (w_init_last) begin
                    r_init_done  <= 1'b1;
                    r_comp_count <= CW'(DEPTH);
                    r_err        <= 1'b0;
                end
            end
            if (w_link_dec) begin
                r_comp_count <= r_comp_count - CW'(1);
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_accept) begin
            assert ((int'(bus.edge_a) < DEPTH) && (int'(bus.edge_b) < DEPTH))
                else $error("uf_union_engine: edge node index out of range");
        end
    end

    assign bus.edge_ready = w_ready;
    assign bus.res_valid  = w_res_valid;
    assign bus.res_merged = w_res_merged;
    assign bus.res_root   = w_res_root;
    assign o_init_done    = r_init_done;
    assign o_comp_count   = r_comp_count;
    assign o_err          = r_err;
    assign o_ram_wen[0]   = w_wen0;
    assign o_ram_waddr[0] = w_waddr0;
    assign o_ram_wdata[0] = w_wdata0;
    assign o_ram_wen[1]   = w_wen1;
    assign o_ram_waddr[1] = w_waddr1;
    assign o_ram_wdata[1] = w_wdata1;

endmodule
`default_nettype wire

// File: tb/tb_uf_union_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uf_union_engine
//  Description : Bench for uf_union_engine. Two engines share the clock:
//                unit 0 with RD_LAT=1, unit 1 with RD_LAT=3, each with its
//                own read-first mdpram model and a reference union-find.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uf_union_engine;

    localparam int D = 8;

    typedef struct {
        bit merged;
        bit chk_root;
        bit err;
        int root;
        int hi;
        int cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n      [2] = '{1'b0, 1'b0};
    logic       init_start [2] = '{1'b0, 1'b0};
    logic       init_done  [2];
    logic [3:0] comp_count [2];
    logic       err        [2];
    logic [2:0] raddr [2][2];
    logic       ren   [2][2];
    logic [2:0] rdata [2][2];
    logic [2:0] waddr [2][2];
    logic       wen   [2][2];
    logic [2:0] wdata [2][2];

    logic [2:0] mem  [2][8];
    logic [2:0] pipe [2][2][3];
    logic       bd_we   [2] = '{1'b0, 1'b0};
    logic [2:0] bd_addr [2];
    logic [2:0] bd_data [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   mpar [2][8];
    int   mcnt [2];
    bit   merr [2];
    exp_t q0[$];
    exp_t q1[$];
    exp_t pend_e [2];
    bit   pend   [2] = '{1'b0, 1'b0};
    int   res_cyc[2] = '{0, 0};

    uf_union_engine_if #(.AW(3)) eif0 ();
    uf_union_engine_if #(.AW(3)) eif1 ();

    uf_union_engine #(.DEPTH(D), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .i_init_start(init_start[0]), .o_init_done(init_done[0]),
        .bus(eif0), .o_comp_count(comp_count[0]), .o_err(err[0]),
        .o_ram_raddr(raddr[0]), .o_ram_ren(ren[0]), .i_ram_rdata(rdata[0]),
        .o_ram_waddr(waddr[0]), .o_ram_wen(wen[0]), .o_ram_wdata(wdata[0])
    );

    uf_union_engine #(.DEPTH(D), .RD_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .i_init_start(init_start[1]), .o_init_done(init_done[1]),
        .bus(eif1), .o_comp_count(comp_count[1]), .o_err(err[1]),
        .o_ram_raddr(raddr[1]), .o_ram_ren(ren[1]), .i_ram_rdata(rdata[1]),
        .o_ram_waddr(waddr[1]), .o_ram_wen(wen[1]), .o_ram_wdata(wdata[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-first mdpram model: the read pipeline shifts only while ren is high.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            for (int p = 0; p < 2; p++) begin
                if (wen[u][p]) mem[u][waddr[u][p]] <= wdata[u][p];
                if (ren[u][p]) begin
                    pipe[u][p][0] <= mem[u][raddr[u][p]];
                    pipe[u][p][1] <= pipe[u][p][0];
                    pipe[u][p][2] <= pipe[u][p][1];
                end
            end
            if (bd_we[u]) mem[u][bd_addr[u]] <= bd_data[u];
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[0][p] = pipe[0][p][0];
            rdata[1][p] = pipe[1][p][2];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rdy(input int u);
        return (u == 0) ? eif0.edge_ready : eif1.edge_ready;
    endfunction
    function automatic logic rv(input int u);
        return (u == 0) ? eif0.res_valid : eif1.res_valid;
    endfunction
    function automatic logic rm(input int u);
        return (u == 0) ? eif0.res_merged : eif1.res_merged;
    endfunction
    function automatic logic [2:0] rr(input int u);
        return (u == 0) ? eif0.res_root : eif1.res_root;
    endfunction
    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction
    function automatic exp_t qpop(input int u);
        return (u == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    task automatic set_edge(input int u, input logic v, input int a, input int b);
        if (u == 0) begin
            eif0.edge_valid = v; eif0.edge_a = 3'(a); eif0.edge_b = 3'(b);
        end else begin
            eif1.edge_valid = v; eif1.edge_a = 3'(a); eif1.edge_b = 3'(b);
        end
    endtask

    task automatic chase(input int u, input int start, output int root, output bit ovf);
        int cur = start;
        int hop = 0;
        ovf = 1'b0;
        for (int h = 0; h < D + 1; h++) begin
            if (mpar[u][cur] == cur) break;
            cur = mpar[u][cur];
            hop++;
            if (hop == D) begin
                ovf = 1'b1;
                break;
            end
        end
        root = cur;
    endtask

    task automatic model_edge(input int u, input int a, input int b, output exp_t e);
        int ra, rb;
        bit oa, ob;
        chase(u, a, ra, oa);
        chase(u, b, rb, ob);
        e.chk_root = 1'b1;
        e.hi       = 0;
        if (oa || ob) begin
            merr[u]    = 1'b1;
            e.merged   = 1'b0;
            e.chk_root = 1'b0;
            e.root     = 0;
        end else if (ra == rb) begin
            e.merged = 1'b0;
            e.root   = ra;
        end else begin
            e.merged = 1'b1;
            e.root   = (ra < rb) ? ra : rb;
            e.hi     = (ra < rb) ? rb : ra;
            mpar[u][e.hi] = e.root;
            mcnt[u]--;
        end
        e.err = merr[u];
        e.cnt = mcnt[u];
    endtask

    task automatic mon(input int u);
        exp_t e;
        if (pend[u]) begin
            check("comp_count", 32'(comp_count[u]), 32'(pend_e[u].cnt));
            check("err_flag", 32'(err[u]), 32'(pend_e[u].err));
            pend[u] = 1'b0;
        end
        if (rv(u)) begin
            check("res_expected", 32'(qsize(u) > 0), 32'd1);
            if (qsize(u) > 0) begin
                e = qpop(u);
                check("res_merged", 32'(rm(u)), 32'(e.merged));
                if (e.chk_root) check("res_root", 32'(rr(u)), 32'(e.root));
                check("link_wen", 32'(wen[u][0]), 32'(e.merged));
                if (e.merged) begin
                    check("link_waddr", 32'(waddr[u][0]), 32'(e.hi));
                    check("link_wdata", 32'(wdata[u][0]), 32'(e.root));
                end
                pend_e[u]  = e;
                pend[u]    = 1'b1;
                res_cyc[u] = cyc;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) mon(u);
    end

    task automatic send_edge(input int u, input int a, input int b, input bit track, output int acc);
        exp_t e;
        int   n = 0;
        if (track) begin
            model_edge(u, a, b, e);
            if (u == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(negedge clk);
        set_edge(u, 1'b1, a, b);
        while (!rdy(u) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 32'(n < 100), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        set_edge(u, 1'b0, 0, 0);
    endtask

    task automatic wait_idle(input int u);
        int n = 0;
        while ((qsize(u) != 0 || pend[u]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("result_in_time", 32'(n < 200), 32'd1);
    endtask

    task automatic do_init(input int u);
        int n = 0;
        @(negedge clk);
        init_start[u] = 1'b1;
        @(posedge clk);
        #1;
        init_start[u] = 1'b0;
        check("init_done_drop", 32'(init_done[u]), 32'd0);
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!init_done[u] && n < 50);
        check("init_cycles", 32'(n), 32'd4);
        for (int i = 0; i < D; i++) mpar[u][i] = i;
        mcnt[u] = D;
        merr[u] = 1'b0;
        check("init_count", 32'(comp_count[u]), 32'd8);
        check("init_err", 32'(err[u]), 32'd0);
        for (int i = 0; i < D; i++) check("init_identity", 32'(mem[u][i]), 32'(i));
    endtask

    task automatic backdoor(input int u, input int addr, input int data);
        @(negedge clk);
        bd_we[u] = 1'b1; bd_addr[u] = 3'(addr); bd_data[u] = 3'(data);
        @(posedge clk);
        #1;
        bd_we[u] = 1'b0;
        mpar[u][addr] = data;
    endtask

    task automatic reset_check(input int u);
        check("rst_init_done", 32'(init_done[u]), 32'd0);
        check("rst_ready", 32'(rdy(u)), 32'd0);
        check("rst_res_valid", 32'(rv(u)), 32'd0);
        check("rst_res_merged", 32'(rm(u)), 32'd0);
        check("rst_res_root", 32'(rr(u)), 32'd0);
        check("rst_count", 32'(comp_count[u]), 32'd0);
        check("rst_err", 32'(err[u]), 32'd0);
        for (int p = 0; p < 2; p++) begin
            check("rst_ren", 32'(ren[u][p]), 32'd0);
            check("rst_wen", 32'(wen[u][p]), 32'd0);
            check("rst_raddr", 32'(raddr[u][p]), 32'd0);
            check("rst_waddr", 32'(waddr[u][p]), 32'd0);
            check("rst_wdata", 32'(wdata[u][p]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        set_edge(0, 1'b0, 0, 0);
        set_edge(1, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_check(0);
        reset_check(1);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        do_init(0);
        do_init(1);

        // Unit 0 (RD_LAT=1): single merge, then a closing edge of a triangle.
        send_edge(0, 3, 5, 1'b1, acc);
        wait_idle(0);
        check("latency_rd1", 32'(res_cyc[0] - acc + 1), 32'd3);
        check("parent5", 32'(mem[0][5]), 32'd3);
        send_edge(0, 5, 6, 1'b1, acc);
        wait_idle(0);
        send_edge(0, 6, 3, 1'b1, acc);
        wait_idle(0);
        send_edge(0, 4, 4, 1'b1, acc);
        wait_idle(0);

        // Corrupt table with a 2-cycle; the chase from 2 must hit the hop limit.
        backdoor(0, 2, 6);
        backdoor(0, 6, 2);
        send_edge(0, 2, 0, 1'b1, acc);
        wait_idle(0);
        check("err_sticky", 32'(err[0]), 32'd1);

        // Unit 1 (RD_LAT=3): build chain 0<-1<-2<-7, then chase from 7.
        send_edge(1, 2, 7, 1'b1, acc); wait_idle(1);
        send_edge(1, 1, 2, 1'b1, acc); wait_idle(1);
        send_edge(1, 0, 1, 1'b1, acc); wait_idle(1);
        check("chain_p7", 32'(mem[1][7]), 32'd2);
        check("chain_p2", 32'(mem[1][2]), 32'd1);
        send_edge(1, 7, 4, 1'b1, acc);
        wait_idle(1);
        check("latency_rd3", 32'(res_cyc[1] - acc + 1), 32'd17);
        check("parent4", 32'(mem[1][4]), 32'd0);

        // Re-init while unit 1 is holding a read in WAIT: edge must vanish.
        send_edge(1, 5, 6, 1'b0, acc);
        @(posedge clk);
        #1;
        check("wait_ren", 32'(ren[1][0]), 32'd1);
        do_init(1);
        repeat (20) @(negedge clk);

        // Async reset during LINK on unit 0.
        send_edge(0, 1, 4, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n[0] = 1'b0;
        #2;
        reset_check(0);
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        do_init(0);
        send_edge(0, 2, 1, 1'b1, acc);
        wait_idle(0);
        check("post_reinit_parent2", 32'(mem[0][2]), 32'd1);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uf_union_engine.md
Name: uf_union_engine

Overview:
- Union-find engine for the circuit-merging stage; drives the 2R+2W parent-pointer RAM (mdpram, DEPTH nodes, WIDTH = $clog2(DEPTH)) directly upstream of it.
- Initialises the parent table to identity, then accepts edges (a,b) one at a time.
- Chases both roots in parallel, one per RAM read port, and links the larger root under the smaller.
- Reports a per-edge merge result and a running component count.

Parameters:
- DEPTH, 1000, number of nodes; parent RAM depth.
- RD_LAT, 1, RAM read latency in ren-cycles; must be >= 1 (fatal otherwise).
- AW, $clog2(DEPTH), node index width; also RAM data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- init_start  in  1  pulse; (re)initialise parent table
- init_done  out  1  high once table is identity, until next init_start
- edge_valid  in  1  edge request valid
- edge_ready  out  1  engine can accept an edge
- edge_a, edge_b  in  AW  node indices (< DEPTH)
- res_valid  out  1  one-cycle result pulse
- res_merged  out  1  1 = roots differed and were linked
- res_root  out  AW  surviving root (min of the two roots)
- comp_count  out  $clog2(DEPTH+1)  current number of components
- err  out  1  sticky; a chase exceeded DEPTH hops
- ram_raddr[2]  out  AW  read addresses
- ram_ren[2]  out  1  read enables
- ram_rdata[2]  in  AW  read data
- ram_waddr[2]  out  AW  write addresses
- ram_wen[2]  out  1  write enables
- ram_wdata[2]  out  AW  write data

Behaviour:
- Reset values: state IDLE; init_done=0; edge_ready=0; res_valid=0; res_merged=0; res_root=0; comp_count=0; err=0; all ren/wen=0; addresses and data=0.
- States: IDLE, INIT, ISSUE, WAIT, CHECK, LINK.
- INIT (entered on init_start from any state, including mid-chase):
  - Each cycle writes parent[k]=k on port 0 and parent[k+1]=k+1 on port 1, k+=2.
  - Port 1 is suppressed when k+1 >= DEPTH.
  - Lasts ceil(DEPTH/2) cycles.
  - On exit: comp_count=DEPTH, init_done=1, err=0, state IDLE.
  - An in-flight edge is dropped with no res_valid.
- edge_ready = (state==IDLE) && init_done.
- Handshake: edge_valid && edge_ready accepts the edge; cur0=a, cur1=b, hop counters cleared.
- RAM read rule: mdpram shifts its read pipeline only while ren is high.
  - ISSUE/WAIT hold ren[p]=1 with raddr[p]=cur_p stable for exactly RD_LAT cycles.
  - ren drops in CHECK, where rdata[p] is sampled.
  - One hop costs RD_LAT+1 cycles.
- CHECK, per port p:
  - If rdata[p]==cur_p, the port is done and stops issuing.
  - Otherwise cur_p=rdata[p], hop_p++, and the port reissues.
  - Ports are independent. The finished port idles (ren=0) while the other keeps chasing.
  - State returns to ISSUE until both ports are done.
- Hop limit: if hop_p reaches DEPTH, set err=1, emit res_valid with res_merged=0 and res_root=cur0, and return to IDLE.
- LINK (one cycle):
  - r0!=r1: wen[0]=1, waddr[0]=max(r0,r1), wdata[0]=min(r0,r1); comp_count--; res_merged=1.
  - r0==r1: no write; res_merged=0.
  - In both cases res_root=min, res_valid=1 in the same cycle, then state IDLE.
- Write port 1 is used only in INIT.
- Read-after-write: the mdpram is read-first. The earliest next accept is the cycle after LINK, so the first read of the next edge issues at least one cycle after the LINK write and sees the new parent.
- a==b: a single chase on both ports gives equal roots, res_merged=0.
- Out-of-range indices (>= DEPTH) are illegal: assertion in sim, no RTL handling.
- comp_count never underflows: a link requires two distinct roots.

Decomposition:
- Package uf_pkg: state enum; localparams AW and CW=$clog2(DEPTH+1); root_min/root_max helper functions.
- One natural sub-module, uf_chase_port, instantiated twice: per-port cur/hop/done registers, ren-hold counter and CHECK compare.
- The top holds the FSM, INIT writer, LINK and counters.

Test Plan:
- DEPTH=8, RD_LAT=1: init_start -> init_done after 4 cycles; backdoor RAM shows parent[i]=i; comp_count=8.
- Edge (3,5) on fresh table -> res_merged=1, res_root=3, parent[5]=3, comp_count=7; accept-to-result 3 cycles (1 hop each + LINK).
- Edges (3,5),(5,6),(6,3) -> third result res_merged=0, res_root=3, comp_count=6, no wen in its LINK.
- RD_LAT=3, chain 0<-1<-2<-7 built via edges, then edge (7,4) -> port 0 chases 4 hops at 4 cycles each while port 1 finishes in 1 hop; result res_root=0, parent[4]=0.
- Backdoor a cycle parent[2]=6, parent[6]=2, edge (2,0) -> err=1 after DEPTH hops, res_merged=0, comp_count unchanged.
- init_start while in WAIT; separately rst_n low mid-LINK -> no res_valid, table re-identity and comp_count=8 after re-init; all outputs at reset values during reset.
